dmem_responder: RTL

// - Data-memory responder serving load/store requests issued by the MEM pipeline stage.
// - Accepts one request per valid/ready handshake, inserts programmable wait states,

---
 rtl/dmem_responder.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// Word-organised data memory answering MEM-stage load/store requests after a fixed number of wait states.
// Optional misalignment trap: define DMEM_MISALIGN_TRAP_EN; otherwise H/W accesses are forced to natural alignment.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_2000,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [2:0]  req_type_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        acc;

  logic        we_q;
  logic [31:0] addr_q;
  logic [2:0]  type_q;
  logic [31:0] wdata_q;

  logic [31:0] mem_q [0:DEPTH_WORDS-1];

  // With zero wait states the access happens on the accept edge, so the live request is used.
  logic        cur_we;
  logic [31:0] cur_addr, cur_wdata, off, rd_word, ldata, wword;
  logic [2:0]  cur_type;
  logic [IDX_W-1:0] idx;
  logic [1:0]  lane;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [3:0]  be;
  logic        range_err, type_err, mis_err, acc_err;

  always_comb begin
    cur_we    = (state_q == S_IDLE) ? req_we_i    : we_q;
    cur_addr  = (state_q == S_IDLE) ? req_addr_i  : addr_q;
    cur_type  = (state_q == S_IDLE) ? req_type_i  : type_q;
    cur_wdata = (state_q == S_IDLE) ? req_wdata_i : wdata_q;

    off       = cur_addr - BASE_ADDR;
    lane      = off[1:0];
    idx       = off[IDX_W+1:2];
    range_err = (cur_addr < BASE_ADDR) || ({2'b00, off[31:2]} >= 32'(DEPTH_WORDS));
    type_err  = (cur_type == 3'b011) || (cur_type[2:1] == 2'b11) || (cur_we && cur_type[2]);
`ifdef DMEM_MISALIGN_TRAP_EN
    mis_err   = ((cur_type[1:0] == 2'b01) && lane[0]) ||
                ((cur_type[1:0] == 2'b10) && (lane != 2'b00));
`else
    mis_err   = 1'b0;
`endif
    acc_err   = range_err || type_err || mis_err;

    rd_word = mem_q[idx];
    byte_v  = rd_word[8*lane +: 8];
    half_v  = lane[1] ? rd_word[31:16] : rd_word[15:0];

    case (cur_type[1:0])
      2'b00: begin
        ldata = cur_type[2] ? {24'b0, byte_v} : {{24{byte_v[7]}}, byte_v};
        be    = 4'b0001 << lane;
        wword = {4{cur_wdata[7:0]}};
      end
      2'b01: begin
        ldata = cur_type[2] ? {16'b0, half_v} : {{16{half_v[15]}}, half_v};
        be    = lane[1] ? 4'b1100 : 4'b0011;
        wword = {2{cur_wdata[15:0]}};
      end
      default: begin
        ldata = rd_word;
        be    = 4'b1111;
        wword = cur_wdata;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    acc     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          if (WAIT_STATES > 0) begin
            state_d = S_WAIT;
            cnt_d   = 4'(WAIT_STATES - 1);
          end else begin
            state_d = S_RESP;
            acc     = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_RESP;
          acc     = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (acc) begin
      err_d   = acc_err;
      rdata_d = (cur_we || acc_err) ? 32'b0 : ldata;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 32'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == S_IDLE && req_valid_i) begin
      we_q    <= req_we_i;
      addr_q  <= req_addr_i;
      type_q  <= req_type_i;
      wdata_q <= req_wdata_i;
    end
  end

  // Read above sees the pre-store word because the write lands on the same edge.
  always_ff @(posedge clk) begin
    if (resetn && acc && cur_we && !acc_err) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem_q[idx][8*b +: 8] <= wword[8*b +: 8];
      end
    end
  end

  assign req_ready_o = (state_q == S_IDLE);
  assign rsp_valid_o = (state_q == S_RESP);
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;

endmodule
